// File: rtl/usb_xact_engine.sv
// Host-side USB transaction sequencer: token, data, handshake phases with
// retry, response timeout and per-endpoint DATA0/DATA1 toggle tracking.
module usb_xact_engine #(
  parameter int DATA_W      = 64,
  parameter int MAX_RETRY   = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              xact_start_i,
  input  logic [1:0]        xact_type_i,
  input  logic [6:0]        xact_addr_i,
  input  logic [3:0]        xact_endp_i,
  input  logic [DATA_W-1:0] xact_wdata_i,
  input  logic              toggle_clr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              success_o,
  output logic [7:0]        attempts_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [3:0]        tx_pid_o,
  output logic [6:0]        tx_addr_o,
  output logic [3:0]        tx_endp_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              rx_valid_i,
  input  logic [3:0]        rx_pid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_err_i
);

  // state       | meaning
  // S_IDLE      | waiting for a legal xact_start
  // S_TOKEN     | presenting OUT/IN token to the encoder
  // S_DATA_TX   | presenting DATA0/DATA1 payload (OUT only)
  // S_WAIT_HS   | waiting for device handshake after OUT data
  // S_WAIT_DATA | waiting for device data after IN token
  // S_SEND_ACK  | presenting ACK for received IN data

  localparam logic [3:0]  PID_OUT   = 4'b0001;
  localparam logic [3:0]  PID_IN    = 4'b1001;
  localparam logic [3:0]  PID_DATA0 = 4'b0011;
  localparam logic [3:0]  PID_DATA1 = 4'b1011;
  localparam logic [3:0]  PID_ACK   = 4'b0010;
  localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);
  localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_DATA_TX, S_WAIT_HS, S_WAIT_DATA, S_SEND_ACK
  } state_t;

  state_t              state_q;
  logic                is_in_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [15:0]         tog_q;
  logic [15:0]         tmo_q;
  logic [7:0]          retry_q;
  logic                pend_q;
  logic                busy_q, done_q, success_q, rdata_valid_q, tx_valid_q;
  logic [7:0]          attempts_q;
  logic [DATA_W-1:0]   rdata_q, tx_data_q;
  logic [3:0]          tx_pid_q, tx_endp_q;
  logic [6:0]          tx_addr_q;

  logic tog_cur, rx_ok, rx_is_data, rx_tog_match, tmo_hit, can_retry, fail_ev;

  always_comb begin
    tog_cur      = tog_q[tx_endp_q];
    rx_ok        = rx_valid_i & ~rx_err_i;
    rx_is_data   = (rx_pid_i == PID_DATA0) || (rx_pid_i == PID_DATA1);
    rx_tog_match = ((rx_pid_i == PID_DATA1) == tog_cur);
    tmo_hit      = ~rx_valid_i && (tmo_q == 16'd0);
    can_retry    = retry_q < RETRY_LIM;
    fail_ev      = 1'b0;
    case (state_q)
      S_WAIT_HS:   fail_ev = tmo_hit || (rx_valid_i && !(rx_ok && rx_pid_i == PID_ACK));
      S_WAIT_DATA: fail_ev = tmo_hit || (rx_valid_i && !(rx_ok && rx_is_data));
      S_SEND_ACK:  fail_ev = tx_ready_i && !pend_q;
      default:     fail_ev = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= S_IDLE;
      is_in_q       <= 1'b0;
      wdata_q       <= '0;
      tog_q         <= '0;
      tmo_q         <= '0;
      retry_q       <= '0;
      pend_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      success_q     <= 1'b0;
      rdata_valid_q <= 1'b0;
      tx_valid_q    <= 1'b0;
      attempts_q    <= '0;
      rdata_q       <= '0;
      tx_data_q     <= '0;
      tx_pid_q      <= '0;
      tx_endp_q     <= '0;
      tx_addr_q     <= '0;
    end else begin
      done_q        <= 1'b0;
      success_q     <= 1'b0;
      rdata_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // busy stays high through the done cycle, so a start there is dropped
          busy_q <= 1'b0;
          if (xact_start_i && !done_q && (xact_type_i == 2'b01 || xact_type_i == 2'b10)) begin
            busy_q     <= 1'b1;
            is_in_q    <= (xact_type_i == 2'b01);
            tx_addr_q  <= xact_addr_i;
            tx_endp_q  <= xact_endp_i;
            wdata_q    <= xact_wdata_i;
            attempts_q <= 8'd1;
            retry_q    <= '0;
            tx_valid_q <= 1'b1;
            tx_pid_q   <= (xact_type_i == 2'b01) ? PID_IN : PID_OUT;
            state_q    <= S_TOKEN;
          end
        end
        S_TOKEN: if (tx_ready_i) begin
          if (is_in_q) begin
            tx_valid_q <= 1'b0;
            tmo_q      <= TMO_LOAD;
            state_q    <= S_WAIT_DATA;
          end else begin
            tx_pid_q  <= tog_cur ? PID_DATA1 : PID_DATA0;
            tx_data_q <= wdata_q;
            state_q   <= S_DATA_TX;
          end
        end
        S_DATA_TX: if (tx_ready_i) begin
          tx_valid_q <= 1'b0;
          tmo_q      <= TMO_LOAD;
          state_q    <= S_WAIT_HS;
        end
        S_WAIT_HS: begin
          if (tmo_q != 16'd0) tmo_q <= tmo_q - 16'd1;
          if (rx_ok && rx_pid_i == PID_ACK) begin
            tog_q[tx_endp_q] <= ~tog_cur;
            done_q    <= 1'b1;
            success_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_WAIT_DATA: begin
          if (tmo_q != 16'd0) tmo_q <= tmo_q - 16'd1;
          // a wrong-toggle DATA is a duplicate: ACK it but keep the old data
          if (rx_ok && rx_is_data) begin
            tx_valid_q <= 1'b1;
            tx_pid_q   <= PID_ACK;
            pend_q     <= rx_tog_match;
            state_q    <= S_SEND_ACK;
            if (rx_tog_match) begin
              rdata_q          <= rx_data_i;
              rdata_valid_q    <= 1'b1;
              tog_q[tx_endp_q] <= ~tog_cur;
            end
          end
        end
        S_SEND_ACK: if (tx_ready_i && pend_q) begin
          tx_valid_q <= 1'b0;
          done_q     <= 1'b1;
          success_q  <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (fail_ev) begin
        if (can_retry) begin
          retry_q    <= retry_q + 8'd1;
          attempts_q <= (attempts_q == 8'hFF) ? 8'hFF : attempts_q + 8'd1;
          tx_valid_q <= 1'b1;
          tx_pid_q   <= is_in_q ? PID_IN : PID_OUT;
          state_q    <= S_TOKEN;
        end else begin
          tx_valid_q <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_IDLE;
        end
      end
      if (toggle_clr_i) tog_q <= '0;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign success_o     = success_q;
  assign attempts_o    = attempts_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign tx_valid_o    = tx_valid_q;
  assign tx_pid_o      = tx_pid_q;
  assign tx_addr_o     = tx_addr_q;
  assign tx_endp_o     = tx_endp_q;
  assign tx_data_o     = tx_data_q;

endmodule

// File: tb/tb_usb_xact_engine.sv
// Directed bench for usb_xact_engine: OUT/IN success, NAK retry, duplicate
// data, timeout, rx_err, toggle clear, backpressure and mid-transaction reset.
module tb_usb_xact_engine;
  localparam int DW = 64;
  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_D0 = 4'b0011,
                         P_D1 = 4'b1011, P_ACK = 4'b0010, P_NAK = 4'b1010;

  logic          clk = 1'b0, rst_b = 1'b0;
  logic          xact_start = 1'b0, toggle_clr = 1'b0;
  logic [1:0]    xact_type = '0;
  logic [6:0]    xact_addr = '0;
  logic [3:0]    xact_endp = '0;
  logic [DW-1:0] xact_wdata = '0;
  logic          busy, done, success, rdata_valid, tx_valid;
  logic [7:0]    attempts;
  logic [DW-1:0] rdata, tx_data;
  logic          tx_ready = 1'b1;
  logic [3:0]    tx_pid, tx_endp;
  logic [6:0]    tx_addr;
  logic          rx_valid = 1'b0, rx_err = 1'b0;
  logic [3:0]    rx_pid = '0;
  logic [DW-1:0] rx_data = '0;

  int checks = 0, errors = 0;

  usb_xact_engine #(.DATA_W(DW), .MAX_RETRY(2), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst_b(rst_b), .xact_start_i(xact_start), .xact_type_i(xact_type),
    .xact_addr_i(xact_addr), .xact_endp_i(xact_endp), .xact_wdata_i(xact_wdata),
    .toggle_clr_i(toggle_clr), .busy_o(busy), .done_o(done), .success_o(success),
    .attempts_o(attempts), .rdata_o(rdata), .rdata_valid_o(rdata_valid),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_pid_o(tx_pid),
    .tx_addr_o(tx_addr), .tx_endp_o(tx_endp), .tx_data_o(tx_data),
    .rx_valid_i(rx_valid), .rx_pid_i(rx_pid), .rx_data_i(rx_data), .rx_err_i(rx_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [1:0] typ, input logic [6:0] addr,
                       input logic [3:0] endp, input logic [DW-1:0] wd);
    xact_start = 1'b1; xact_type = typ; xact_addr = addr; xact_endp = endp; xact_wdata = wd;
    tick();
    xact_start = 1'b0;
  endtask

  task automatic rx_pulse(input logic [3:0] pid, input logic [DW-1:0] d, input logic err);
    rx_valid = 1'b1; rx_pid = pid; rx_data = d; rx_err = err;
    tick();
    rx_valid = 1'b0; rx_err = 1'b0;
  endtask

  // OUT with ACK on the first wait cycle; done must land 4 cycles after start
  task automatic out_xact(input logic [3:0] endp, input logic [DW-1:0] wd,
                          input logic [3:0] exp_dpid, input string tag);
    start(2'b10, 7'h12, endp, wd);
    chk({tag, "_tok_pid"}, tx_pid, P_OUT);
    chk({tag, "_tok_endp"}, tx_endp, endp);
    chk({tag, "_tok_addr"}, tx_addr, 7'h12);
    tick();
    chk({tag, "_data_pid"}, tx_pid, exp_dpid);
    chk({tag, "_data"}, tx_data, wd);
    tick();
    chk({tag, "_wait_idle_tx"}, tx_valid, 1'b0);
    rx_pulse(P_ACK, '0, 1'b0);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_success"}, success, 1'b1);
    chk({tag, "_attempts"}, attempts, 8'd1);
    chk({tag, "_busy_at_done"}, busy, 1'b1);
    tick();
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int ack_seen;
    int done_seen;
    logic stable;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_attempts", attempts, 8'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst_b = 1'b1;
    tick();

    // OUT success, then repeat to the same endpoint uses DATA1
    out_xact(4'd3, 64'hDEAD_BEEF_0123_4567, P_D0, "out1");
    out_xact(4'd3, 64'h1111_2222_3333_4444, P_D1, "out2");

    // illegal type is ignored
    xact_start = 1'b1; xact_type = 2'b11;
    tick();
    xact_start = 1'b0;
    chk("illegal_type_busy", busy, 1'b0);

    // three NAKs exhaust MAX_RETRY=2
    start(2'b10, 7'h12, 4'd5, 64'hABCD);
    for (int a = 0; a < 3; a++) begin
      chk("nak_tok_pid", tx_pid, P_OUT);
      chk("nak_tok_valid", tx_valid, 1'b1);
      tick();
      chk("nak_data_pid", tx_pid, P_D0);
      tick();
      rx_pulse(P_NAK, '0, 1'b0);
    end
    chk("nak_done", done, 1'b1);
    chk("nak_success", success, 1'b0);
    chk("nak_attempts", attempts, 8'd3);
    xact_start = 1'b1; xact_type = 2'b10;
    tick();
    xact_start = 1'b0;
    chk("start_at_done_busy", busy, 1'b0);
    chk("start_at_done_txv", tx_valid, 1'b0);
    out_xact(4'd5, 64'h5555, P_D0, "nak_tog");

    // IN: duplicate DATA1, then good DATA0
    start(2'b01, 7'h21, 4'd2, '0);
    chk("in_tok_pid", tx_pid, P_IN);
    tick();
    chk("in_wait_txv", tx_valid, 1'b0);
    rx_pulse(P_D1, 64'h1234, 1'b0);
    chk("dup_no_rvalid", rdata_valid, 1'b0);
    chk("dup_ack_pid", tx_pid, P_ACK);
    chk("dup_ack_valid", tx_valid, 1'b1);
    tick();
    chk("dup_retry_pid", tx_pid, P_IN);
    chk("dup_retry_att", attempts, 8'd2);
    chk("dup_no_done", done, 1'b0);
    tick();
    rx_pulse(P_D0, 64'h55AA, 1'b0);
    chk("in_rvalid", rdata_valid, 1'b1);
    chk("in_rdata", rdata, 64'h55AA);
    chk("in_ack_pid", tx_pid, P_ACK);
    tick();
    chk("in_done", done, 1'b1);
    chk("in_success", success, 1'b1);
    chk("in_attempts", attempts, 8'd2);
    tick();

    // timeout: token re-issued exactly 10 cycles after entering WAIT_DATA
    start(2'b01, 7'h21, 4'd6, '0);
    tick();
    stable = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      stable = stable | tx_valid;
    end
    chk("tmo_quiet", stable, 1'b0);
    tick();
    chk("tmo_reissue_valid", tx_valid, 1'b1);
    chk("tmo_reissue_pid", tx_pid, P_IN);
    ack_seen = 0; done_seen = 0;
    for (int k = 0; k < 60 && done_seen == 0; k++) begin
      tick();
      if (tx_valid && tx_pid == P_ACK) ack_seen++;
      if (done) begin
        done_seen = 1;
        chk("tmo_success", success, 1'b0);
        chk("tmo_attempts", attempts, 8'd3);
      end
    end
    chk("tmo_done_seen", done_seen, 1);
    chk("tmo_no_ack", ack_seen, 0);
    tick();

    // rx_err on DATA0: no ACK, retry succeeds
    start(2'b01, 7'h21, 4'd7, '0);
    tick();
    rx_pulse(P_D0, 64'hBAD, 1'b1);
    chk("err_retry_pid", tx_pid, P_IN);
    chk("err_no_rvalid", rdata_valid, 1'b0);
    chk("err_attempts", attempts, 8'd2);
    tick();
    rx_pulse(P_D0, 64'hCAFE, 1'b0);
    chk("err_rvalid", rdata_valid, 1'b1);
    chk("err_rdata", rdata, 64'hCAFE);
    tick();
    chk("err_done", done, 1'b1);
    chk("err_success", success, 1'b1);
    tick();

    // toggle_clr: endp 7 expects DATA0 again
    toggle_clr = 1'b1;
    tick();
    toggle_clr = 1'b0;
    start(2'b01, 7'h21, 4'd7, '0);
    tick();
    rx_pulse(P_D0, 64'h77, 1'b0);
    chk("clr_rvalid", rdata_valid, 1'b1);
    chk("clr_rdata", rdata, 64'h77);
    tick();
    chk("clr_done", done, 1'b1);
    chk("clr_attempts", attempts, 8'd1);
    tick();

    // backpressure, then reset while in WAIT_HS
    tx_ready = 1'b0;
    start(2'b10, 7'h05, 4'd1, 64'h99);
    for (int k = 0; k < 5; k++) begin
      stable = tx_valid && tx_pid == P_OUT && tx_addr == 7'h05 && tx_endp == 4'd1;
      chk("bp_stable", stable, 1'b1);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    chk("bp_data_pid", tx_pid, P_D0);
    tick();
    chk("bp_wait_txv", tx_valid, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_txv", tx_valid, 1'b0);
    tick();
    chk("rst_mid_done", done, 1'b0);
    rst_b = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
